// File: rtl/bank_timing_sched.sv
// Per-bank DDR command timing scheduler: open-row tracking, PRE/ACT/CAS sequencing
// and periodic refresh, all strobes one cycle wide and registered.
module bank_timing_sched #(
  parameter int TRCD  = 11,
  parameter int TRP   = 11,
  parameter int TCCD  = 4,
  parameter int TRFC  = 208,
  parameter int TREFI = 6240
) (
  input  logic        CK_t,
  input  logic        reset_n,
  input  logic        init_done,
  input  logic        cmd_rdy,
  input  logic [2:0]  request,
  input  logic [1:0]  bg_addr,
  input  logic [1:0]  ba_addr,
  input  logic [13:0] row_addr,
  output logic        busy,
  output logic        act_rdy,
  output logic        no_act_rdy,
  output logic        cas_rdy,
  output logic        pre_rdy,
  output logic        prea_rdy,
  output logic        refresh_rdy,
  output logic [2:0]  cas_req
);

  localparam int MAX_A = (TRFC > TREFI) ? TRFC : TREFI;
  localparam int MAX_B = (TRCD > TRP) ? TRCD : TRP;
  localparam int MAX_C = (MAX_B > TCCD) ? MAX_B : TCCD;
  localparam int MAXW  = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CW    = $clog2(MAXW + 1);

  localparam logic [CW-1:0] TRCD_M1  = CW'(TRCD - 1);
  localparam logic [CW-1:0] TRP_M1   = CW'(TRP - 1);
  localparam logic [CW-1:0] TCCD_M1  = CW'(TCCD - 1);
  localparam logic [CW-1:0] TRFC_M1  = CW'(TRFC - 1);
  localparam logic [CW-1:0] TREFI_M1 = CW'(TREFI - 1);

  localparam logic [2:0] NOP_R = 3'd0;
  localparam logic [2:0] RDA_R = 3'd3;
  localparam logic [2:0] WRA_R = 3'd4;

  typedef enum logic [3:0] {
    IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, CAS, CAS_WAIT,
    PREA, PREA_WAIT, REF, REF_WAIT
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  timer;
  logic           ref_pend;
  logic [2:0]     req_q;
  logic [3:0]     idx_q;
  logic [13:0]    row_q;
  logic [15:0]    tab_valid;
  logic [13:0]    tab_row [16];

  logic [3:0] idx_in;
  logic       wrap;
  logic       hit;
  logic       accept;
  logic       idle_busy;

  // Handshake: a request is taken on a rising edge where cmd_rdy=1, busy=0,
  // init_done=1 and request is a real command; a refresh due on that same edge wins.
  assign idx_in    = {bg_addr, ba_addr};
  assign wrap      = init_done && (timer == TREFI_M1);
  assign hit       = tab_valid[idx_in] && (tab_row[idx_in] == row_addr);
  assign accept    = (state == IDLE) && !ref_pend && !wrap && cmd_rdy && !busy &&
                     init_done && (request != NOP_R) && (request <= WRA_R);
  assign idle_busy = ref_pend | wrap | !init_done;

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      timer       <= '0;
      ref_pend    <= 1'b0;
      req_q       <= '0;
      idx_q       <= '0;
      row_q       <= '0;
      tab_valid   <= '0;
      for (int i = 0; i < 16; i++) tab_row[i] <= '0;
      busy        <= 1'b1;
      act_rdy     <= 1'b0;
      no_act_rdy  <= 1'b0;
      cas_rdy     <= 1'b0;
      pre_rdy     <= 1'b0;
      prea_rdy    <= 1'b0;
      refresh_rdy <= 1'b0;
      cas_req     <= '0;
    end else begin
      act_rdy     <= 1'b0;
      no_act_rdy  <= 1'b0;
      cas_rdy     <= 1'b0;
      pre_rdy     <= 1'b0;
      prea_rdy    <= 1'b0;
      refresh_rdy <= 1'b0;
      cas_req     <= '0;

      if (init_done) timer <= wrap ? '0 : timer + 1'b1;
      // A wrap while a refresh is already pending simply re-sets the same flag.
      if (wrap) ref_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (ref_pend || wrap) begin
            busy <= 1'b1;
            if (|tab_valid) begin
              state    <= PREA;
              prea_rdy <= 1'b1;
              cnt      <= TRP_M1;
            end else begin
              state       <= REF;
              refresh_rdy <= 1'b1;
              cnt         <= TRFC_M1;
              ref_pend    <= 1'b0;
              tab_valid   <= '0;
            end
          end else if (accept) begin
            busy  <= 1'b1;
            req_q <= request;
            idx_q <= idx_in;
            row_q <= row_addr;
            if (hit) begin
              state      <= ACT;
              no_act_rdy <= 1'b1;
              cnt        <= '0;
            end else if (tab_valid[idx_in]) begin
              state   <= PRE;
              pre_rdy <= 1'b1;
              cnt     <= TRP_M1;
            end else begin
              state              <= ACT;
              act_rdy            <= 1'b1;
              cnt                <= TRCD_M1;
              tab_valid[idx_in]  <= 1'b1;
              tab_row[idx_in]    <= row_addr;
            end
          end else begin
            busy <= !init_done;
          end
        end

        PRE, PRE_WAIT: begin
          if (cnt == '0) begin
            state            <= ACT;
            act_rdy          <= 1'b1;
            cnt              <= TRCD_M1;
            tab_valid[idx_q] <= 1'b1;
            tab_row[idx_q]   <= row_q;
          end else begin
            state <= PRE_WAIT;
            cnt   <= cnt - 1'b1;
          end
        end

        // ACT also covers the row-hit path, where it holds for exactly one cycle.
        ACT, ACT_WAIT: begin
          if (cnt == '0) begin
            state   <= CAS;
            cas_rdy <= 1'b1;
            cas_req <= req_q;
            cnt     <= TCCD_M1;
            if (req_q == RDA_R || req_q == WRA_R) tab_valid[idx_q] <= 1'b0;
          end else begin
            state <= ACT_WAIT;
            cnt   <= cnt - 1'b1;
          end
        end

        CAS, CAS_WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= idle_busy;
          end else begin
            state <= CAS_WAIT;
            cnt   <= cnt - 1'b1;
          end
        end

        PREA, PREA_WAIT: begin
          if (cnt == '0) begin
            state       <= REF;
            refresh_rdy <= 1'b1;
            cnt         <= TRFC_M1;
            ref_pend    <= 1'b0;
            tab_valid   <= '0;
          end else begin
            state <= PREA_WAIT;
            cnt   <= cnt - 1'b1;
          end
        end

        REF, REF_WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= idle_busy;
          end else begin
            state <= REF_WAIT;
            cnt   <= cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bank_timing_sched.sv
// Directed bench for bank_timing_sched: stimulus pushes expected strobe/busy-fall
// events with their cycle numbers, a negedge monitor pops and compares them.
module tb_bank_timing_sched;

  localparam int TRCD  = 3;
  localparam int TRP   = 2;
  localparam int TCCD  = 4;
  localparam int TRFC  = 5;
  localparam int TREFI = 40;
  localparam int W     = 22;

  localparam logic [2:0] EV_ACT   = 3'd1;
  localparam logic [2:0] EV_NOACT = 3'd2;
  localparam logic [2:0] EV_CAS   = 3'd3;
  localparam logic [2:0] EV_PRE   = 3'd4;
  localparam logic [2:0] EV_PREA  = 3'd5;
  localparam logic [2:0] EV_REF   = 3'd6;
  localparam logic [2:0] EV_BFALL = 3'd7;

  logic        CK_t = 1'b0;
  logic        reset_n = 1'b0;
  logic        init_done = 1'b0;
  logic        cmd_rdy = 1'b0;
  logic [2:0]  request = '0;
  logic [1:0]  bg_addr = '0;
  logic [1:0]  ba_addr = '0;
  logic [13:0] row_addr = '0;
  logic        busy, act_rdy, no_act_rdy, cas_rdy, pre_rdy, prea_rdy, refresh_rdy;
  logic [2:0]  cas_req;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  bit   mon_en = 1'b0;
  logic prev_busy = 1'b1;
  int   nstb;

  bank_timing_sched #(
    .TRCD(TRCD), .TRP(TRP), .TCCD(TCCD), .TRFC(TRFC), .TREFI(TREFI)
  ) dut (
    .CK_t(CK_t), .reset_n(reset_n), .init_done(init_done), .cmd_rdy(cmd_rdy),
    .request(request), .bg_addr(bg_addr), .ba_addr(ba_addr), .row_addr(row_addr),
    .busy(busy), .act_rdy(act_rdy), .no_act_rdy(no_act_rdy), .cas_rdy(cas_rdy),
    .pre_rdy(pre_rdy), .prea_rdy(prea_rdy), .refresh_rdy(refresh_rdy), .cas_req(cas_req)
  );

  // clock / reset block
  always #5 CK_t = ~CK_t;
  always @(posedge CK_t) cyc <= cyc + 1;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ev(input logic [2:0] code, input logic [2:0] req, input int c);
    logic [15:0] c16;
    c16 = c[15:0];
    return {code, req, c16};
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic push_ev(input logic [2:0] code, input logic [2:0] req, input int c);
    exp_q.push_back(ev(code, req, c));
  endtask

  task automatic got_event(input logic [2:0] code);
    logic [W-1:0] obs, exp_v;
    obs = ev(code, cas_req, cyc + 1);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got code %0d req %0d cyc %0d, expected none",
               obs[21:19], obs[18:16], obs[15:0]);
    end else begin
      exp_v = exp_q.pop_front();
      if (exp_v != obs) begin
        n_fail++;
        $display("FAIL event: got code %0d req %0d cyc %0d, expected code %0d req %0d cyc %0d",
                 obs[21:19], obs[18:16], obs[15:0], exp_v[21:19], exp_v[18:16], exp_v[15:0]);
      end
    end
  endtask

  // scoreboard monitor
  always @(negedge CK_t) begin
    if (mon_en) begin
      nstb = int'(act_rdy) + int'(no_act_rdy) + int'(cas_rdy) + int'(pre_rdy) +
             int'(prea_rdy) + int'(refresh_rdy);
      if (nstb != 0) begin
        check("strobe_onehot", (nstb > 1) ? 1 : 0, 0);
        if (act_rdy)          got_event(EV_ACT);
        else if (no_act_rdy)  got_event(EV_NOACT);
        else if (cas_rdy)     got_event(EV_CAS);
        else if (pre_rdy)     got_event(EV_PRE);
        else if (prea_rdy)    got_event(EV_PREA);
        else                  got_event(EV_REF);
      end
      if (prev_busy && !busy) got_event(EV_BFALL);
      prev_busy = busy;
    end
  end

  // driver tasks
  task automatic wait_until(input int e);
    while (cyc + 1 < e) @(negedge CK_t);
  endtask

  task automatic issue(input logic [2:0] req, input logic [1:0] bg, input logic [1:0] ba,
                       input logic [13:0] row, input int hold);
    cmd_rdy  = 1'b1;
    request  = req;
    bg_addr  = bg;
    ba_addr  = ba;
    row_addr = row;
    repeat (hold) @(negedge CK_t);
    cmd_rdy  = 1'b0;
    request  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_strobes"}, int'(act_rdy) + int'(no_act_rdy) + int'(cas_rdy) +
          int'(pre_rdy) + int'(prea_rdy) + int'(refresh_rdy), 0);
    check({tag, "_cas_req"}, cas_req, 0);
  endtask

  int i0, i2;

  initial begin
    @(negedge CK_t);
    mon_en = 1'b1;
    check_reset_outputs("rst0");
    repeat (2) @(negedge CK_t);
    reset_n = 1'b1;
    @(negedge CK_t);
    check("busy_no_init", busy, 1);
    @(negedge CK_t);
    check("busy_no_init2", busy, 1);

    i0 = cyc + 1;
    init_done = 1'b1;
    push_ev(EV_BFALL, 3'd0, i0 + 1);

    // closed bank: ACT then CAS after TRCD
    wait_until(i0 + 1);
    push_ev(EV_ACT, 3'd0, i0 + 2);
    push_ev(EV_CAS, 3'd1, i0 + 5);
    push_ev(EV_BFALL, 3'd0, i0 + 9);
    issue(3'd1, 2'd1, 2'd2, 14'h0A5, 1);

    // row hit
    wait_until(i0 + 9);
    push_ev(EV_NOACT, 3'd0, i0 + 10);
    push_ev(EV_CAS, 3'd1, i0 + 11);
    push_ev(EV_BFALL, 3'd0, i0 + 15);
    issue(3'd1, 2'd1, 2'd2, 14'h0A5, 1);

    // row conflict
    wait_until(i0 + 15);
    push_ev(EV_PRE, 3'd0, i0 + 16);
    push_ev(EV_ACT, 3'd0, i0 + 18);
    push_ev(EV_CAS, 3'd2, i0 + 21);
    push_ev(EV_BFALL, 3'd0, i0 + 25);
    issue(3'd2, 2'd1, 2'd2, 14'h0A6, 1);

    // RDA to the new row hits (table now holds 0x0A6) and closes the bank
    wait_until(i0 + 25);
    push_ev(EV_NOACT, 3'd0, i0 + 26);
    push_ev(EV_CAS, 3'd3, i0 + 27);
    push_ev(EV_BFALL, 3'd0, i0 + 31);
    issue(3'd3, 2'd1, 2'd2, 14'h0A6, 1);

    wait_until(i0 + 31);
    push_ev(EV_ACT, 3'd0, i0 + 32);
    push_ev(EV_CAS, 3'd1, i0 + 35);
    push_ev(EV_BFALL, 3'd0, i0 + 39);
    issue(3'd1, 2'd1, 2'd2, 14'h0A6, 1);

    // timer wraps on the same edge the host requests: refresh goes first
    wait_until(i0 + 39);
    push_ev(EV_PREA, 3'd0, i0 + 40);
    push_ev(EV_REF, 3'd0, i0 + 42);
    push_ev(EV_BFALL, 3'd0, i0 + 47);
    push_ev(EV_ACT, 3'd0, i0 + 48);
    push_ev(EV_CAS, 3'd3, i0 + 51);
    push_ev(EV_BFALL, 3'd0, i0 + 55);
    issue(3'd3, 2'd1, 2'd2, 14'h0A6, 9);

    // next wrap with every bank closed: refresh without PREA
    push_ev(EV_REF, 3'd0, i0 + 80);
    push_ev(EV_BFALL, 3'd0, i0 + 85);

    wait_until(i0 + 86);
    push_ev(EV_ACT, 3'd0, i0 + 87);
    issue(3'd1, 2'd0, 2'd0, 14'h123, 1);

    // reset pulse in ACT_WAIT
    wait_until(i0 + 88);
    #2;
    reset_n = 1'b0;
    init_done = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) @(negedge CK_t);
    check_reset_outputs("rst_hold");
    reset_n = 1'b1;
    repeat (2) @(negedge CK_t);
    check("busy_after_rst", busy, 1);

    i2 = cyc + 1;
    init_done = 1'b1;
    push_ev(EV_BFALL, 3'd0, i2 + 1);
    wait_until(i2 + 1);
    push_ev(EV_ACT, 3'd0, i2 + 2);
    push_ev(EV_CAS, 3'd1, i2 + 5);
    push_ev(EV_BFALL, 3'd0, i2 + 9);
    issue(3'd1, 2'd0, 2'd0, 14'h123, 1);

    wait_until(i2 + 14);
    check("leftover_events", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
